// File: rtl/csr_file.sv
// csr_file: architectural CSR storage with registered reads, atomic
// 48-bit counter reads via HI shadows, write-first bypass and illegal flag.
module csr_file #(
    parameter int unsigned P_IDX_W       = 12,
    parameter logic [23:0] P_ID_VAL      = 24'h0A4B01,
    parameter logic [23:0] P_STATUS_MASK = 24'h0000FF
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic               iw_rd_en,
    input  logic [P_IDX_W-1:0] iw_rd_idx,
    input  logic               iw_stall,
    output logic [23:0]        ow_rd_data,
    output logic               ow_rd_valid,
    input  logic               iw_wr_en,
    input  logic [P_IDX_W-1:0] iw_wr_idx,
    input  logic [23:0]        iw_wr_data,
    input  logic               iw_retire,
    output logic               ow_illegal,
    output logic [23:0]        ow_status
);

    localparam int unsigned DW = 24;
    localparam int unsigned CW = 48;

    localparam logic [P_IDX_W-1:0] IDX_STATUS   = P_IDX_W'(12'h000);
    localparam logic [P_IDX_W-1:0] IDX_SCRATCH0 = P_IDX_W'(12'h001);
    localparam logic [P_IDX_W-1:0] IDX_SCRATCH1 = P_IDX_W'(12'h002);
    localparam logic [P_IDX_W-1:0] IDX_CYC_LO   = P_IDX_W'(12'h010);
    localparam logic [P_IDX_W-1:0] IDX_CYC_HI   = P_IDX_W'(12'h011);
    localparam logic [P_IDX_W-1:0] IDX_INST_LO  = P_IDX_W'(12'h012);
    localparam logic [P_IDX_W-1:0] IDX_INST_HI  = P_IDX_W'(12'h013);
    localparam logic [P_IDX_W-1:0] IDX_ID       = P_IDX_W'(12'h0F0);

    logic [DW-1:0] status_q,   status_d;
    logic [DW-1:0] scratch0_q, scratch0_d;
    logic [DW-1:0] scratch1_q, scratch1_d;
    logic [CW-1:0] cycle_q,    cycle_d;
    logic [CW-1:0] instret_q,  instret_d;
    logic [DW-1:0] cyc_hi_q,   cyc_hi_d;
    logic [DW-1:0] inst_hi_q,  inst_hi_d;
    logic [DW-1:0] rd_data_q,  rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          illegal_q,  illegal_d;

    logic          wr_rw;
    logic [DW-1:0] wr_val;
    logic          wr_do;
    logic          rd_fire;
    logic          rd_mapped;
    logic [DW-1:0] rd_raw;
    logic [DW-1:0] rd_next;

    // Decode the write index: only RW CSRs accept data, STATUS is masked
    always_comb begin
        wr_rw  = 1'b0;
        wr_val = iw_wr_data;
        case (iw_wr_idx)
            IDX_STATUS: begin
                wr_rw  = 1'b1;
                wr_val = iw_wr_data & P_STATUS_MASK;
            end
            IDX_SCRATCH0, IDX_SCRATCH1: wr_rw = 1'b1;
            default: wr_rw = 1'b0;
        endcase
    end

    // Read mux over current CSR state; unmapped indices read as zero
    always_comb begin
        rd_mapped = 1'b1;
        rd_raw    = '0;
        case (iw_rd_idx)
            IDX_STATUS:   rd_raw = status_q;
            IDX_SCRATCH0: rd_raw = scratch0_q;
            IDX_SCRATCH1: rd_raw = scratch1_q;
            IDX_CYC_LO:   rd_raw = cycle_q[DW-1:0];
            IDX_CYC_HI:   rd_raw = cyc_hi_q;
            IDX_INST_LO:  rd_raw = instret_q[DW-1:0];
            IDX_INST_HI:  rd_raw = inst_hi_q;
            IDX_ID:       rd_raw = P_ID_VAL;
            default:      rd_mapped = 1'b0;
        endcase
    end

    // Next-state: writes, counters, shadows, read response and illegal flag
    always_comb begin
        status_d   = status_q;
        scratch0_d = scratch0_q;
        scratch1_d = scratch1_q;
        cyc_hi_d   = cyc_hi_q;
        inst_hi_d  = inst_hi_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;

        wr_do   = iw_wr_en & wr_rw;
        rd_fire = iw_rd_en & ~iw_stall;
        rd_next = (wr_do && (iw_wr_idx == iw_rd_idx)) ? wr_val : rd_raw;

        cycle_d   = cycle_q + CW'(1);
        instret_d = instret_q + CW'(iw_retire);

        if (wr_do) begin
            case (iw_wr_idx)
                IDX_STATUS:   status_d   = wr_val;
                IDX_SCRATCH0: scratch0_d = wr_val;
                IDX_SCRATCH1: scratch1_d = wr_val;
                default:      status_d   = status_q;
            endcase
        end

        if (rd_fire) begin
            rd_data_d = rd_next;
            if (iw_rd_idx == IDX_CYC_LO)  cyc_hi_d  = cycle_q[CW-1:DW];
            if (iw_rd_idx == IDX_INST_LO) inst_hi_d = instret_q[CW-1:DW];
        end

        if (!iw_stall) rd_valid_d = iw_rd_en;

        illegal_d = (iw_wr_en & ~wr_rw) | (rd_fire & ~rd_mapped);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            status_q   <= '0;
            scratch0_q <= '0;
            scratch1_q <= '0;
            cycle_q    <= '0;
            instret_q  <= '0;
            cyc_hi_q   <= '0;
            inst_hi_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            status_q   <= status_d;
            scratch0_q <= scratch0_d;
            scratch1_q <= scratch1_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
            cyc_hi_q   <= cyc_hi_d;
            inst_hi_q  <= inst_hi_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ow_rd_data  = rd_data_q;
    assign ow_rd_valid = rd_valid_q;
    assign ow_illegal  = illegal_q;
    assign ow_status   = status_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file against a behavioural CSR model.
module tb_csr_file;

    logic        iw_clk = 1'b0;
    logic        iw_rst;
    logic        iw_rd_en;
    logic [11:0] iw_rd_idx;
    logic        iw_stall;
    logic [23:0] ow_rd_data;
    logic        ow_rd_valid;
    logic        iw_wr_en;
    logic [11:0] iw_wr_idx;
    logic [23:0] iw_wr_data;
    logic        iw_retire;
    logic        ow_illegal;
    logic [23:0] ow_status;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [23:0] m_status, m_s0, m_s1, m_ch, m_ih, m_rd_data;
    logic [47:0] m_cyc, m_inst;
    logic        m_rd_valid, m_ill;

    csr_file dut (
        .iw_clk      (iw_clk),
        .iw_rst      (iw_rst),
        .iw_rd_en    (iw_rd_en),
        .iw_rd_idx   (iw_rd_idx),
        .iw_stall    (iw_stall),
        .ow_rd_data  (ow_rd_data),
        .ow_rd_valid (ow_rd_valid),
        .iw_wr_en    (iw_wr_en),
        .iw_wr_idx   (iw_wr_idx),
        .iw_wr_data  (iw_wr_data),
        .iw_retire   (iw_retire),
        .ow_illegal  (ow_illegal),
        .ow_status   (ow_status)
    );

    always #5 iw_clk = ~iw_clk;

    function automatic bit is_rw(input logic [11:0] idx);
        return (idx == 12'h000) || (idx == 12'h001) || (idx == 12'h002);
    endfunction

    function automatic bit is_mapped(input logic [11:0] idx);
        return is_rw(idx) || (idx >= 12'h010 && idx <= 12'h013) || (idx == 12'h0F0);
    endfunction

    function automatic logic [23:0] model_read(input logic [11:0] idx);
        case (idx)
            12'h000: return m_status;
            12'h001: return m_s0;
            12'h002: return m_s1;
            12'h010: return m_cyc[23:0];
            12'h011: return m_ch;
            12'h012: return m_inst[23:0];
            12'h013: return m_ih;
            12'h0F0: return 24'h0A4B01;
            default: return 24'h000000;
        endcase
    endfunction

    // Drive one clock of stimulus and advance the model; returns #1 after the edge
    task automatic cyc(input logic rst, input logic rd, input logic [11:0] ridx,
                       input logic st, input logic wr, input logic [11:0] widx,
                       input logic [23:0] wd, input logic ret);
        logic [23:0] wv;
        bit          wok, rf;
        @(negedge iw_clk);
        iw_rst = rst; iw_rd_en = rd; iw_rd_idx = ridx; iw_stall = st;
        iw_wr_en = wr; iw_wr_idx = widx; iw_wr_data = wd; iw_retire = ret;
        if (rst) begin
            m_status = 0; m_s0 = 0; m_s1 = 0; m_ch = 0; m_ih = 0;
            m_cyc = 0; m_inst = 0; m_rd_data = 0; m_rd_valid = 0; m_ill = 0;
        end else begin
            wv  = (widx == 12'h000) ? (wd & 24'h0000FF) : wd;
            wok = wr && is_rw(widx);
            rf  = rd && !st;
            if (rf) begin
                m_rd_data = (wok && widx == ridx) ? wv : model_read(ridx);
                if (ridx == 12'h010) m_ch = m_cyc[47:24];
                if (ridx == 12'h012) m_ih = m_inst[47:24];
            end
            if (!st) m_rd_valid = rd;
            m_ill = (wr && !wok) || (rf && !is_mapped(ridx));
            if (wok) begin
                if (widx == 12'h000) m_status = wv;
                if (widx == 12'h001) m_s0 = wv;
                if (widx == 12'h002) m_s1 = wv;
            end
            m_cyc  = m_cyc + 48'd1;
            m_inst = m_inst + 48'(ret);
        end
        @(posedge iw_clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 12'h000, 0, 0, 12'h000, 24'h0, 0);
    endtask

    task automatic test_reset();
        cyc(1, 0, 12'h000, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b exp 0", ow_rd_valid); end
        n_cmp++; if (ow_rd_data !== 24'h0) begin n_bad++; $display("FAIL reset_data got %h exp 0", ow_rd_data); end
        n_cmp++; if (ow_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %0b exp 0", ow_illegal); end
        n_cmp++; if (ow_status !== 24'h0) begin n_bad++; $display("FAIL reset_status got %h exp 0", ow_status); end
        idle();
        cyc(0, 1, 12'h0F0, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_data !== 24'h0A4B01 || ow_rd_valid !== 1'b1 || ow_illegal !== 1'b0) begin
            n_bad++; $display("FAIL read_id got %h/%0b/%0b exp 0a4b01/1/0", ow_rd_data, ow_rd_valid, ow_illegal);
        end
        idle();
        n_cmp++; if (ow_rd_valid !== 1'b0) begin n_bad++; $display("FAIL valid_drop got %0b exp 0", ow_rd_valid); end
    endtask

    task automatic test_rw();
        cyc(0, 0, 12'h000, 0, 1, 12'h001, 24'h00EF12, 0);
        cyc(0, 1, 12'h001, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_data !== 24'h00EF12) begin n_bad++; $display("FAIL scratch0 got %h exp 00ef12", ow_rd_data); end
        cyc(0, 1, 12'h000, 0, 1, 12'h000, 24'hFFFFFF, 0);
        n_cmp++; if (ow_rd_data !== 24'h0000FF) begin n_bad++; $display("FAIL status_bypass got %h exp 0000ff", ow_rd_data); end
        n_cmp++; if (ow_status !== 24'h0000FF) begin n_bad++; $display("FAIL ow_status got %h exp 0000ff", ow_status); end
        idle();
    endtask

    task automatic test_instret();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 12'h000, 0, 0, 12'h000, 24'h0, 1);
            idle();
        end
        cyc(0, 1, 12'h012, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_data !== 24'h000005 || ow_rd_data !== m_rd_data) begin
            n_bad++; $display("FAIL instret_lo got %h exp 000005", ow_rd_data);
        end
        cyc(0, 1, 12'h013, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_data !== 24'h0) begin n_bad++; $display("FAIL instret_hi got %h exp 0", ow_rd_data); end
        idle();
    endtask

    task automatic test_illegal();
        cyc(0, 0, 12'h000, 0, 1, 12'h010, 24'h123456, 0);
        n_cmp++; if (ow_illegal !== 1'b1) begin n_bad++; $display("FAIL ro_write_ill got %0b exp 1", ow_illegal); end
        idle();
        n_cmp++; if (ow_illegal !== 1'b0) begin n_bad++; $display("FAIL ill_pulse_end got %0b exp 0", ow_illegal); end
        cyc(0, 1, 12'h010, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_data !== m_rd_data) begin n_bad++; $display("FAIL cycle_untouched got %h exp %h", ow_rd_data, m_rd_data); end
        cyc(0, 1, 12'h7FF, 0, 1, 12'h0F0, 24'h111111, 0);
        n_cmp++; if (ow_rd_data !== 24'h0 || ow_rd_valid !== 1'b1 || ow_illegal !== 1'b1) begin
            n_bad++; $display("FAIL unmapped_rd got %h/%0b/%0b exp 0/1/1", ow_rd_data, ow_rd_valid, ow_illegal);
        end
        idle();
        n_cmp++; if (ow_illegal !== 1'b0) begin n_bad++; $display("FAIL dual_ill_single got %0b exp 0", ow_illegal); end
    endtask

    task automatic test_stall();
        cyc(0, 0, 12'h000, 0, 1, 12'h002, 24'hABCDEF, 0);
        cyc(0, 1, 12'h001, 0, 0, 12'h000, 24'h0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 12'h002, 1, 0, 12'h000, 24'h0, 0);
            n_cmp++; if (ow_rd_data !== 24'h00EF12 || ow_rd_valid !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold[%0d] got %h/%0b exp 00ef12/1", i, ow_rd_data, ow_rd_valid);
            end
        end
        cyc(0, 1, 12'h002, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_data !== 24'hABCDEF) begin n_bad++; $display("FAIL stall_release got %h exp abcdef", ow_rd_data); end
        idle();
    endtask

    task automatic test_random();
        logic [11:0] tbl [10] = '{12'h000, 12'h001, 12'h002, 12'h010, 12'h011,
                                  12'h012, 12'h013, 12'h0F0, 12'h7FF, 12'h003};
        for (int i = 0; i < 300; i++) begin
            cyc(0, 1'($urandom_range(0, 2) != 0), tbl[$urandom_range(0, 9)],
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
                tbl[$urandom_range(0, 9)], 24'($urandom), 1'($urandom));
            n_cmp++; if (ow_rd_valid !== m_rd_valid || ow_illegal !== m_ill || ow_status !== m_status ||
                         (m_rd_valid && ow_rd_data !== m_rd_data)) begin
                n_bad++;
                $display("FAIL random[%0d] got v=%0b d=%h i=%0b s=%h exp v=%0b d=%h i=%0b s=%h", i,
                         ow_rd_valid, ow_rd_data, ow_illegal, ow_status, m_rd_valid, m_rd_data, m_ill, m_status);
            end
        end
        idle();
    endtask

    task automatic test_cycle_snapshot();
        @(negedge iw_clk);
        force dut.cycle_q = 48'h0000_01FF_FFFF;
        m_cyc = 48'h0000_01FF_FFFF;
        cyc(0, 1, 12'h010, 0, 0, 12'h000, 24'h0, 0);
        release dut.cycle_q;
        n_cmp++; if (ow_rd_data !== 24'hFFFFFF) begin n_bad++; $display("FAIL cycle_lo got %h exp ffffff", ow_rd_data); end
        idle();
        cyc(0, 1, 12'h011, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_data !== 24'h000001) begin n_bad++; $display("FAIL cycle_hi_snap got %h exp 000001", ow_rd_data); end
        idle();
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 12'h001, 0, 0, 12'h000, 24'h0, 0);
        cyc(1, 1, 12'h001, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_valid !== 1'b0 || ow_rd_data !== 24'h0 || ow_status !== 24'h0) begin
            n_bad++; $display("FAIL mid_reset got %0b/%h/%h exp 0/0/0", ow_rd_valid, ow_rd_data, ow_status);
        end
        cyc(0, 1, 12'h010, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_data !== 24'h0) begin n_bad++; $display("FAIL post_rst_cycle got %h exp 0", ow_rd_data); end
        cyc(0, 1, 12'h010, 0, 0, 12'h000, 24'h0, 0);
        n_cmp++; if (ow_rd_data !== 24'h1) begin n_bad++; $display("FAIL post_rst_cycle1 got %h exp 1", ow_rd_data); end
        for (int k = 0; k < 5; k++) begin
            logic [11:0] ix;
            ix = (k < 3) ? 12'(k) : ((k == 3) ? 12'h011 : 12'h012);
            cyc(0, 1, ix, 0, 0, 12'h000, 24'h0, 0);
            n_cmp++; if (ow_rd_data !== 24'h0) begin n_bad++; $display("FAIL post_rst_csr[%h] got %h exp 0", ix, ow_rd_data); end
        end
        idle();
    endtask

    initial begin
        iw_rst = 1'b1; iw_rd_en = 0; iw_rd_idx = 0; iw_stall = 0;
        iw_wr_en = 0; iw_wr_idx = 0; iw_wr_data = 0; iw_retire = 0;
        test_reset();
        test_rw();
        test_instret();
        test_illegal();
        test_stall();
        test_random();
        test_cycle_snapshot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Architectural CSR storage that answers the execute stage's CSRRD reads and takes CSRWR writebacks from WB.
- Holds the status, scratch, 48-bit cycle/instret counters and a read-only ID, all exposed as 24-bit views.
- Read data is registered with 1-cycle latency and feeds the stage that drives iw_src_sr_val's low 24 bits.
- Illegal accesses are flagged for the trap logic.

Parameters:
- P_IDX_W, 12, CSR index width.
- P_ID_VAL, 24'h0A4B01, value returned by the ID CSR.
- P_STATUS_MASK, 24'h0000FF, writable bits of STATUS; other bits always read 0.

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  synchronous, active-high reset.
- iw_rd_en  in  1  read request this cycle.
- iw_rd_idx  in  P_IDX_W  read CSR index.
- iw_stall  in  1  hold read response registers.
- ow_rd_data  out  24  read data, valid the cycle after the request.
- ow_rd_valid  out  1  ow_rd_data valid.
- iw_wr_en  in  1  write request (WB stage of CSRWR).
- iw_wr_idx  in  P_IDX_W  write CSR index.
- iw_wr_data  in  24  write data.
- iw_retire  in  1  one instruction retired this cycle.
- ow_illegal  out  1  1-cycle pulse: bad index or write to a read-only CSR.
- ow_status  out  24  current STATUS, for the pipeline.

Behaviour:
- Map:
  - 0x000 STATUS, RW, masked by P_STATUS_MASK.
  - 0x001 SCRATCH0, RW.
  - 0x002 SCRATCH1, RW.
  - 0x010 CYCLE_LO, RO.
  - 0x011 CYCLE_HI, RO.
  - 0x012 INSTRET_LO, RO.
  - 0x013 INSTRET_HI, RO.
  - 0x0F0 ID, RO, returns P_ID_VAL.
  - Any other index is unmapped.
- Reset, synchronous on iw_rst at a rising edge:
  - STATUS, SCRATCH0/1, cycle, instret, both HI shadows = 0.
  - ow_rd_data = 0, ow_rd_valid = 0, ow_illegal = 0.
  - Reset mid-operation discards any in-flight read response.
  - The first post-reset edge leaves cycle = 1.
- cycle counter:
  - 48 bits, increments every non-reset cycle, including stalls.
  - Wraps from 48'hFFFF_FFFF_FFFF to 0.
- instret counter:
  - 48 bits, +1 on each cycle with iw_retire = 1; same wrap rule.
- Read timing:
  - Request at edge N gives ow_rd_data / ow_rd_valid = 1 after edge N.
  - ow_rd_valid = 0 after any edge with iw_rd_en = 0 and iw_stall = 0.
- Stall:
  - While iw_stall = 1, ow_rd_data, ow_rd_valid and the HI shadows hold; new read requests are ignored.
  - Writes, counters and ow_illegal are unaffected by stall.
- Atomic 48-bit reads:
  - Reading CYCLE_LO returns cycle[23:0] as of the sampling edge and copies cycle[47:24] into cyc_hi_shadow at that edge.
  - Reading CYCLE_HI returns cyc_hi_shadow.
  - INSTRET_LO/HI use the same scheme with inst_hi_shadow.
  - HI with no prior LO read returns 0 after reset.
- Write-first bypass:
  - If iw_wr_en and iw_rd_en target the same RW index in the same cycle, the read returns the new (masked) value.
- Writes:
  - Take effect at the edge.
  - STATUS stores iw_wr_data & P_STATUS_MASK.
- ow_illegal:
  - Pulses 1 for the cycle after any of: a write to an RO index; a write to an unmapped index; a read of an unmapped index.
  - An ignored or illegal write changes no state.
  - An unmapped read returns 0 with ow_rd_valid = 1.
  - Illegal read and illegal write in the same cycle give a single pulse.

Test Plan:
- Reset, then read ID -> the next cycle shows ow_rd_data = 24'h0A4B01, ow_rd_valid = 1, ow_illegal = 0.
- Write SCRATCH0 = 24'h00EF12, then read SCRATCH0 -> 24'h00EF12. Also write STATUS = 24'hFFFFFF and read it in the same cycle -> 24'h0000FF via bypass, and ow_status = 24'h0000FF.
- Force cycle = 48'h0000_01FF_FFFF (by waiting or a bench override), read CYCLE_LO then CYCLE_HI two cycles later -> HI = 24'h000001, i.e. the snapshot value, not the incremented value.
- Pulse iw_retire 5 times with gaps, read INSTRET_LO -> 24'h000005; read INSTRET_HI -> 0.
- Write CYCLE_LO = 24'h123456 -> ow_illegal pulses once and the counter is unaffected. Read index 0x7FF -> data 0, ow_illegal pulses.
- Read SCRATCH1 while iw_stall = 1 for 3 cycles -> ow_rd_data keeps its prior value, then updates 1 cycle after stall drops. Assert iw_rst during a pending read -> ow_rd_valid = 0 and all CSRs = 0.
